// File: rtl/alu_issue_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_pkg
//   Shared definitions for the ALU issue/writeback controller:
//     - W / NREG      : data width and register count
//     - RA_W / OPC_W  : register-address and opcode field widths
//     - state_t       : controller FSM states
//     - instr_t       : packed view of one 12-bit instruction word
//     - field bit positions, for anyone decoding raw words by hand
// ---------------------------------------------------------------------------
package alu_issue_pkg;

  localparam int W     = 12;
  localparam int NREG  = 4;
  localparam int RA_W  = 2;
  localparam int OPC_W = 3;

  // Instruction field bit positions.
  localparam int OPC_MSB = 11;
  localparam int OPC_LSB = 9;
  localparam int RD_MSB  = 8;
  localparam int RD_LSB  = 7;
  localparam int RS1_MSB = 6;
  localparam int RS1_LSB = 5;
  localparam int RS2_MSB = 4;
  localparam int RS2_LSB = 3;
  localparam int PAD_MSB = 2;
  localparam int PAD_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  // The first member is the most significant, so this layout matches the
  // bit positions above.
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [RA_W-1:0]  rd;
    logic [RA_W-1:0]  rs1;
    logic [RA_W-1:0]  rs2;
    logic [2:0]       pad;
  } instr_t;

  // A word whose low three bits are not all zero is malformed.
  function automatic logic instr_is_legal(input instr_t ins);
    return (ins.pad == 3'b000);
  endfunction

endpackage

// File: rtl/regfile4x12.sv
// ---------------------------------------------------------------------------
// regfile4x12
//   Small register file for the issue controller: two combinational read
//   ports and one synchronous write port. Synchronous reset clears every
//   entry, so it is built from flops rather than block RAM.
//
//   Ports:
//     clk        in   clock
//     rst        in   synchronous active-high reset, clears all entries
//     i_we       in   write enable
//     i_waddr    in   write address
//     i_wdata    in   write data
//     i_raddr_a  in   read port A address
//     o_rdata_a  out  read port A data (combinational)
//     i_raddr_b  in   read port B address
//     o_rdata_b  out  read port B data (combinational)
// ---------------------------------------------------------------------------
module regfile4x12
  import alu_issue_pkg::*;
#(
  parameter int DW = alu_issue_pkg::W,
  parameter int NR = alu_issue_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [RA_W-1:0] i_waddr,
  input  logic [DW-1:0]   i_wdata,
  input  logic [RA_W-1:0] i_raddr_a,
  output logic [DW-1:0]   o_rdata_a,
  input  logic [RA_W-1:0] i_raddr_b,
  output logic [DW-1:0]   o_rdata_b
);

  logic [DW-1:0] r_mem [NR];

  // One write-decode per entry; each entry owns its own flop group.
  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          r_mem[gi] <= '0;
        end else if (i_we && (i_waddr == RA_W'(gi))) begin
          r_mem[gi] <= i_wdata;
        end
      end
    end
  endgenerate

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Issue/writeback controller in front of a combinational 12-bit ALU.
//   Accepts one instruction at a time (valid/ready), reads two operands
//   from a 4x12 register file, drives the ALU, captures the result and
//   writes it back. The sequence is strictly IDLE -> READ -> EXEC -> WB,
//   which gives one instruction per four cycles.
//
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     instr_valid   in   instruction offered on instr
//     instr_ready   out  controller is in IDLE and not in reset
//     instr         in   {opcode[11:9], rd[8:7], rs1[6:5], rs2[4:3], 000}
//     ld_en         in   direct register load, honoured only in IDLE
//     ld_addr       in   register to load
//     ld_data       in   load value
//     alu_opcode    out  ALU opcode (registered)
//     alu_op1       out  ALU operand 1 = RF[rs1] (registered)
//     alu_op2       out  ALU operand 2 = RF[rs2] (registered)
//     alu_out       in   ALU result, combinational from the three above
//     res_valid     out  one-cycle pulse while the result is written back
//     res_rd        out  destination register of the result
//     res_data      out  result value
//     err           out  one-cycle pulse for a malformed instruction
//     busy          out  controller is not in IDLE
// ---------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int NREG = alu_issue_pkg::NREG,
  parameter int W    = alu_issue_pkg::W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [W-1:0]     instr,
  input  logic             ld_en,
  input  logic [RA_W-1:0]  ld_addr,
  input  logic [W-1:0]     ld_data,
  output logic [OPC_W-1:0] alu_opcode,
  output logic [W-1:0]     alu_op1,
  output logic [W-1:0]     alu_op2,
  input  logic [W-1:0]     alu_out,
  output logic             res_valid,
  output logic [RA_W-1:0]  res_rd,
  output logic [W-1:0]     res_data,
  output logic             err,
  output logic             busy
);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_next;

  instr_t           r_instr;
  logic [OPC_W-1:0] r_opcode;
  logic [W-1:0]     r_op1;
  logic [W-1:0]     r_op2;
  logic [W-1:0]     r_result;
  logic             r_err;

  logic             w_handshake;
  logic             w_legal;

  // Register file write port, shared by direct loads and writeback.
  logic             w_rf_we;
  logic [RA_W-1:0]  w_rf_waddr;
  logic [W-1:0]     w_rf_wdata;
  logic [W-1:0]     w_rf_rdata_a;
  logic [W-1:0]     w_rf_rdata_b;

  assign w_handshake = instr_valid && instr_ready;
  assign w_legal     = instr_is_legal(r_instr);

  // -------------------------------------------------------------------------
  // Register file. Read addresses come straight from the latched instruction,
  // so during READ the ports already show RF[rs1] / RF[rs2], including any
  // load that landed on the handshake edge.
  // -------------------------------------------------------------------------
  regfile4x12 #(
    .DW (W),
    .NR (NREG)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_rf_we),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata),
    .i_raddr_a (r_instr.rs1),
    .o_rdata_a (w_rf_rdata_a),
    .i_raddr_b (r_instr.rs2),
    .o_rdata_b (w_rf_rdata_b)
  );

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_handshake) w_state_next = READ;
      READ:    w_state_next = w_legal ? EXEC : IDLE;
      EXEC:    w_state_next = WB;
      WB:      w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs and write-port steering
  // -------------------------------------------------------------------------
  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    res_valid   = 1'b0;
    w_rf_we     = 1'b0;
    w_rf_waddr  = ld_addr;
    w_rf_wdata  = ld_data;
    case (r_state)
      IDLE: begin
        // Held low during reset so nothing is accepted on the reset edge.
        instr_ready = !rst;
        busy        = 1'b0;
        w_rf_we     = ld_en;
      end
      WB: begin
        res_valid  = 1'b1;
        w_rf_we    = 1'b1;
        w_rf_waddr = r_instr.rd;
        w_rf_wdata = r_result;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers. The ALU-facing registers only move in READ, so the
  // ALU inputs stay stable through EXEC and hold their values while idle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr  <= '0;
      r_opcode <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;

      if (w_handshake) begin
        r_instr <= instr_t'(instr);
      end

      if (r_state == READ) begin
        if (!w_legal) begin
          // Malformed word: flag it and leave the ALU drive untouched.
          r_err <= 1'b1;
        end else begin
          r_opcode <= r_instr.opcode;
          r_op1    <= w_rf_rdata_a;
          r_op2    <= w_rf_rdata_b;
        end
      end

      if (r_state == EXEC) begin
        r_result <= alu_out;
      end
    end
  end

  assign alu_opcode = r_opcode;
  assign alu_op1    = r_op1;
  assign alu_op2    = r_op2;
  assign res_rd     = r_instr.rd;
  assign res_data   = r_result;
  assign err        = r_err;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue/writeback controller sitting directly upstream of the 12-bit ALU. Accepts one 12-bit instruction at a time over a valid/ready handshake, reads two operands from an internal 4x12 register file, drives the ALU's opcode and operand inputs, captures the ALU result and writes it back to the destination register. Also reports each result and flags malformed instructions.

## Interface
Parameters:
- NREG, 4, register count; fixed at 4 by the 2-bit register fields.
- W, 12, data and instruction width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  upstream has an instruction on instr.
- instr_ready  out  1  controller can accept; high only in IDLE.
- instr  in  12  [11:9] ALU opcode, [8:7] rd, [6:5] rs1, [4:3] rs2, [2:0] must be 000.
- ld_en  in  1  direct register load, honoured only in IDLE.
- ld_addr  in  2  register to load.
- ld_data  in  12  load value.
- alu_opcode  out  3  to ALU opcode.
- alu_op1  out  12  to ALU op1 (RF[rs1]).
- alu_op2  out  12  to ALU op2 (RF[rs2]).
- alu_out  in  12  ALU result, combinational from the three outputs above.
- res_valid  out  1  one-cycle pulse on writeback.
- res_rd  out  2  destination of the pulsed result.
- res_data  out  12  value written.
- err  out  1  one-cycle pulse on illegal instruction.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, READ, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid: latch instr into instruction register, go to READ. Otherwise stay.
- ld_en in IDLE writes RF[ld_addr]=ld_data at that edge. ld_en outside IDLE is ignored, with no effect on the RF.
- ld_en and instr_valid together in IDLE: both take effect. READ then sees the loaded value.
- READ: if latched instr[2:0]!=000, pulse err next cycle and go to IDLE, with no ALU drive change and no writeback. Otherwise load the operand registers: opcode=instr[11:9], op1=RF[rs1], op2=RF[rs2]. Go to EXEC.
- EXEC: operand registers hold steady. At the end of the cycle, capture alu_out into the result register. Go to WB.
- WB: RF[rd]=result at the end of the cycle. res_valid=1, res_rd=rd and res_data=result during this cycle. Go to IDLE.
- rs1, rs2 and rd may alias. Reads in READ always see pre-writeback contents; there is no forwarding hazard because execution is strictly sequential.
- Arithmetic is the ALU's concern. The controller passes 12-bit values unmodified and performs no extension.
- alu_opcode, alu_op1 and alu_op2 hold their last values in IDLE and change only in READ.

## Timing
- Handshake fires at edge k, when instr_valid and instr_ready are both high. State is READ in cycle k+1, EXEC in k+2 and WB in k+3. res_valid is high during k+3 and RF is updated at the end of k+3. instr_ready returns high in k+4.
- Throughput: one instruction per 4 cycles.
- Illegal instruction: err is high in cycle k+2, and instr_ready is high again in k+2.
- Reset values: state IDLE; all RF entries 0; operand, opcode and result registers 0; res_valid=0, err=0, busy=0, res_rd=0, res_data=0. instr_ready=0 while rst is high, 1 in the first cycle after.
- Reset mid-operation, in any state: abandon the instruction. No writeback, no res_valid and no err are produced. Return to reset values next cycle.
- instr_valid while not ready: no acceptance. The upstream holds instr until the handshake.

## Structure
- Shared package alu_issue_pkg: state enum (IDLE, READ, EXEC, WB), instruction field bit positions, W and NREG constants.
- One sub-module, regfile4x12: two combinational read ports and one synchronous write port with enable; reset clears all entries. Load-port and writeback writes share the write port, muxed by state. The two never coincide because loads occur only in IDLE.

## Test plan
The bench uses a stub ALU: alu_out = (alu_op1 + alu_op2) mod 4096.

- Reset, then ld R1=0x005 and ld R2=0x003, then instr 0x0A8 (op0, rd=1, rs1=1, rs2=1). Expect res_valid exactly 3 cycles after the handshake, with res_rd=1 and res_data=0x00A.
- Load R0=0xFFF and R3=0x002, then instr rd=2, rs1=0, rs2=3. Expect res_data=0x001 (wrap) and R2=0x001. alu_opcode must equal instr[11:9] through EXEC.
- instr 0x0A9 (low bits 001): err pulses in cycle k+2, no res_valid, RF unchanged, instr_ready high again in k+2.
- ld_en with ld_addr=1 and ld_data=0x100, plus instr_valid with rs1=1, rs2=1 in the same IDLE cycle: expect res_data=0x200.
- Assert rst during EXEC of an instruction targeting R2=0x7: no res_valid, all RF entries read 0 afterward, instr_ready high in the cycle after rst deasserts.
- Hold instr_valid continuously over 3 back-to-back instructions: exactly 3 res_valid pulses, spaced 4 cycles apart. ld_en asserted while busy leaves the RF unchanged.
